// File: rtl/ws2812_rx_pkg.sv
// ws2812_rx_pkg: shared WS2812 timing constants at 12 MHz, receiver states and the GRB->RGB reorder.
// Both the transmitter and the receiver import these constants, so they agree on pulse widths.
package ws2812_rx_pkg;
   localparam int T0H         = 4;
   localparam int T1H         = 8;
   localparam int T0L         = 8;
   localparam int T1L         = 4;
   localparam int T_RESET_CYC = 600;
   typedef enum logic [2:0] {SYNC_WAIT, IDLE, HIGH, LOW, ERROR} state_e;
   // The wire carries G,R,B MSB first; pixels are presented as {R,G,B}.
   function automatic logic [23:0] grb_to_rgb(input logic [23:0] grb);
      return {grb[15:8], grb[23:16], grb[7:0]};
   endfunction
endpackage

// File: rtl/ws2812_rx_if.sv
// ws2812_rx_if: serial line input and decoded pixel/frame outputs of the WS2812 receiver.
interface ws2812_rx_if;
   logic        din;
   logic [23:0] rgb_data;
   logic [7:0]  led_num;
   logic        pixel_valid;
   logic        frame_done;
   logic [7:0]  led_count;
   logic        overflow;
   logic        bit_error;
   modport master (output din, input rgb_data, led_num, pixel_valid, frame_done, led_count, overflow, bit_error);
   modport slave  (input din, output rgb_data, led_num, pixel_valid, frame_done, led_count, overflow, bit_error);
endinterface

// File: rtl/ws2812_sync_edge.sv
// ws2812_sync_edge: 2-flop synchronizer for an asynchronous line plus registered rise/fall strobes.
module ws2812_sync_edge (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);
   logic s1_q, s2_q, d_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         d_q  <= 1'b0;
      end else begin
         s1_q <= d_i;
         s2_q <= s1_q;
         d_q  <= s2_q;
      end
   end
   assign level_o = s2_q;
   assign rise_o  = s2_q & ~d_q;
   assign fall_o  = ~s2_q & d_q;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 single-wire decoder; classifies high pulses into bits, assembles 24-bit pixels
// and detects the latch gap that ends a frame.
module ws2812_rx
   import ws2812_rx_pkg::*;
#(
   parameter int NUM_LEDS     = 16,
   parameter int T_BIT_THRESH = 6,
   parameter int T_HIGH_MIN   = 2,
   parameter int T_HIGH_MAX   = 14,
   parameter int T_RESET      = T_RESET_CYC
) (
   input logic         clk,
   input logic         reset,
   ws2812_rx_if.slave  bus
);
   localparam int LW = $clog2(T_RESET + 1);
   if (T_BIT_THRESH > T_HIGH_MAX || T_BIT_THRESH <= T_HIGH_MIN) begin : g_bad_timing
      $error("ws2812_rx: need T_HIGH_MIN < T_BIT_THRESH <= T_HIGH_MAX");
   end
   logic din_s, rise, fall;
   ws2812_sync_edge u_sync (
      .clk    (clk),
      .reset  (reset),
      .d_i    (bus.din),
      .level_o(din_s),
      .rise_o (rise),
      .fall_o (fall)
   );
   state_e          state_q, state_d;
   logic [4:0]      hcnt_q, hcnt_d;
   logic [LW-1:0]   lcnt_q, lcnt_d, lcnt_inc;
   logic [4:0]      bit_cnt_q, bit_cnt_d;
   logic [7:0]      pix_idx_q, pix_idx_d;
   logic [23:0]     sh_q, sh_d, sh_in;
   logic [23:0]     rgb_q, rgb_d;
   logic [7:0]      led_num_q, led_num_d;
   logic [7:0]      led_count_q, led_count_d;
   logic            pv_q, pv_d, fd_q, fd_d, ov_q, ov_d, be_q, be_d;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= SYNC_WAIT;
         hcnt_q      <= '0;
         lcnt_q      <= '0;
         bit_cnt_q   <= '0;
         pix_idx_q   <= '0;
         sh_q        <= '0;
         rgb_q       <= '0;
         led_num_q   <= '0;
         led_count_q <= '0;
         pv_q        <= 1'b0;
         fd_q        <= 1'b0;
         ov_q        <= 1'b0;
         be_q        <= 1'b0;
      end else begin
         state_q     <= state_d;
         hcnt_q      <= hcnt_d;
         lcnt_q      <= lcnt_d;
         bit_cnt_q   <= bit_cnt_d;
         pix_idx_q   <= pix_idx_d;
         sh_q        <= sh_d;
         rgb_q       <= rgb_d;
         led_num_q   <= led_num_d;
         led_count_q <= led_count_d;
         pv_q        <= pv_d;
         fd_q        <= fd_d;
         ov_q        <= ov_d;
         be_q        <= be_d;
      end
   end
   // hcnt counts synchronized high cycles; at the falling strobe it equals the pulse width.
   always_comb begin
      state_d     = state_q;
      hcnt_d      = hcnt_q;
      lcnt_d      = lcnt_q;
      bit_cnt_d   = bit_cnt_q;
      pix_idx_d   = pix_idx_q;
      sh_d        = sh_q;
      rgb_d       = rgb_q;
      led_num_d   = led_num_q;
      led_count_d = led_count_q;
      pv_d        = 1'b0;
      fd_d        = 1'b0;
      ov_d        = 1'b0;
      be_d        = 1'b0;
      lcnt_inc    = (lcnt_q == LW'(T_RESET)) ? lcnt_q : lcnt_q + 1'b1;
      sh_in       = {sh_q[22:0], hcnt_q >= 5'(T_BIT_THRESH)};
      case (state_q)
         SYNC_WAIT, ERROR: begin
            lcnt_d = din_s ? '0 : lcnt_inc;
            if (!din_s && lcnt_inc == LW'(T_RESET)) begin
               state_d = IDLE;
               lcnt_d  = '0;
            end
         end
         IDLE: begin
            if (rise) begin
               state_d   = HIGH;
               hcnt_d    = 5'd1;
               bit_cnt_d = '0;
               pix_idx_d = '0;
            end
         end
         HIGH: begin
            if (hcnt_q > 5'(T_HIGH_MAX)) begin
               be_d    = 1'b1;
               state_d = ERROR;
               lcnt_d  = '0;
            end else if (fall) begin
               state_d = LOW;
               lcnt_d  = LW'(1);
               if (hcnt_q < 5'(T_HIGH_MIN)) begin
                  be_d = 1'b1;
               end else begin
                  sh_d      = sh_in;
                  bit_cnt_d = bit_cnt_q + 5'd1;
                  if (bit_cnt_q == 5'd23) begin
                     bit_cnt_d = '0;
                     rgb_d     = grb_to_rgb(sh_in);
                     led_num_d = pix_idx_q;
                     pv_d      = 1'b1;
                     ov_d      = pix_idx_q >= 8'(NUM_LEDS);
                     pix_idx_d = (pix_idx_q == 8'd255) ? pix_idx_q : pix_idx_q + 8'd1;
                  end
               end
            end else begin
               hcnt_d = (hcnt_q == 5'd31) ? hcnt_q : hcnt_q + 5'd1;
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
               hcnt_d  = 5'd1;
            end else if (lcnt_inc == LW'(T_RESET)) begin
               fd_d        = 1'b1;
               led_count_d = pix_idx_q;
               be_d        = bit_cnt_q != 5'd0;
               bit_cnt_d   = '0;
               lcnt_d      = '0;
               state_d     = IDLE;
            end else begin
               lcnt_d = lcnt_inc;
            end
         end
         default: state_d = SYNC_WAIT;
      endcase
   end
   assign bus.rgb_data    = rgb_q;
   assign bus.led_num     = led_num_q;
   assign bus.pixel_valid = pv_q;
   assign bus.frame_done  = fd_q;
   assign bus.led_count   = led_count_q;
   assign bus.overflow    = ov_q;
   assign bus.bit_error   = be_q;
endmodule
